// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - instruction-memory responder with programmable latency
// In-order req/gnt/rvalid responder over a loadable word array; bad addresses answer with a NOP and err.
module instr_mem_responder #(
    parameter int                    WORD_WIDTH      = 32,
    parameter int                    DEPTH_WORDS     = 1024,
    parameter logic [WORD_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    LATENCY         = 1,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req_i,
    input  logic [WORD_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [WORD_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,
    input  logic                  load_en_i,
    input  logic [WORD_WIDTH-1:0] load_addr_i,
    input  logic [WORD_WIDTH-1:0] load_data_i
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [WORD_WIDTH-1:0] DEPTH_LIM = WORD_WIDTH'(DEPTH_WORDS);
    localparam logic [WORD_WIDTH-1:0] NOP_WORD  = WORD_WIDTH'(32'h0000_0013);
    localparam logic [CW-1:0]         MAX_CNT   = CW'(MAX_OUTSTANDING);

    // Returns {bad, idx}; the offset wraps modulo 2^WORD_WIDTH so addresses below BASE_ADDR are out of range.
    function automatic logic [AW:0] decode(input logic [WORD_WIDTH-1:0] addr);
        logic [WORD_WIDTH-1:0] off;
        logic [WORD_WIDTH-1:0] sh;
        off = addr - BASE_ADDR;
        sh  = off >> 2;
        return {(addr[1:0] != 2'b00) || (sh >= DEPTH_LIM), sh[AW-1:0]};
    endfunction

    logic [AW:0]           req_dec;
    logic [AW:0]           load_dec;
    logic [CW-1:0]         outstanding;
    logic                  head_v;
    logic [AW-1:0]         head_idx;
    logic                  head_err;
    logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

    assign req_dec  = decode(instr_addr_i);
    assign load_dec = decode(load_addr_i);

    assign instr_gnt_o = instr_req_i & ~rst & ~load_en_i & (outstanding < MAX_CNT);

    // The output register is the last pipeline stage, so only LATENCY-1 stages are held here.
    generate
        if (LATENCY == 1) begin : g_direct
            assign head_v   = instr_gnt_o;
            assign head_idx = req_dec[AW-1:0];
            assign head_err = req_dec[AW];
        end else begin : g_pipe
            logic [LATENCY-2:0] pipe_v;
            logic [LATENCY-2:0] pipe_err;
            logic [AW-1:0]      pipe_idx [LATENCY-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_v <= '0;
                end else begin
                    pipe_v[0] <= instr_gnt_o;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipe_v[i] <= pipe_v[i-1];
                    end
                end
                pipe_err[0] <= req_dec[AW];
                pipe_idx[0] <= req_dec[AW-1:0];
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipe_err[i] <= pipe_err[i-1];
                    pipe_idx[i] <= pipe_idx[i-1];
                end
            end

            assign head_v   = pipe_v[LATENCY-2];
            assign head_idx = pipe_idx[LATENCY-2];
            assign head_err = pipe_err[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (load_en_i && !load_dec[AW]) begin
            mem[load_dec[AW-1:0]] <= load_data_i;
        end
    end

    // A load on the read edge is not seen here because mem updates with the same nonblocking edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_rvalid_o <= 1'b0;
            instr_rdata_o  <= '0;
            instr_err_o    <= 1'b0;
        end else begin
            instr_rvalid_o <= head_v;
            instr_err_o    <= head_v & head_err;
            if (head_v) begin
                instr_rdata_o <= head_err ? NOP_WORD : mem[head_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (instr_gnt_o && !instr_rvalid_o) begin
            outstanding <= outstanding + 1'b1;
        end else if (!instr_gnt_o && instr_rvalid_o) begin
            outstanding <= outstanding - 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - directed vector bench for instr_mem_responder
// One LATENCY=1 instance driven from a cycle table, one LATENCY=3 instance driven by hand-written sequences.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld;
    logic [31:0] la, ldd;
    logic        req1, gnt1, rv1, err1;
    logic [31:0] addr1, rd1;
    logic        req3, gnt3, rv3, err3;
    logic [31:0] addr3, rd3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_mem_responder #(
        .WORD_WIDTH(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h100), .LATENCY(1), .MAX_OUTSTANDING(2)
    ) u1 (
        .clk(clk), .rst(rst), .instr_req_i(req1), .instr_addr_i(addr1), .instr_gnt_o(gnt1),
        .instr_rvalid_o(rv1), .instr_rdata_o(rd1), .instr_err_o(err1),
        .load_en_i(ld), .load_addr_i(la), .load_data_i(ldd)
    );

    instr_mem_responder #(
        .WORD_WIDTH(32), .DEPTH_WORDS(16), .BASE_ADDR(32'h100), .LATENCY(3), .MAX_OUTSTANDING(2)
    ) u3 (
        .clk(clk), .rst(rst), .instr_req_i(req3), .instr_addr_i(addr3), .instr_gnt_o(gnt3),
        .instr_rvalid_o(rv3), .instr_rdata_o(rd3), .instr_err_o(err3),
        .load_en_i(ld), .load_addr_i(la), .load_data_i(ldd)
    );

    typedef struct {
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic        ld;
        logic [31:0] la;
        logic [31:0] ldd;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic q, input logic [31:0] a, input logic l,
                       input logic [31:0] lad, input logic [31:0] ldat, input logic g,
                       input logic v, input logic [31:0] d, input logic e);
        vec_t x;
        x.rst = r; x.req = q; x.addr = a; x.ld = l; x.la = lad; x.ldd = ldat;
        x.gnt = g; x.rv = v; x.rd = d; x.err = e;
        vt.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc3(input logic r, input logic q, input logic [31:0] a, input logic l,
                        input logic [31:0] lad, input logic [31:0] ldat);
        @(negedge clk);
        rst = r; req3 = q; addr3 = a; ld = l; la = lad; ldd = ldat;
        #1;
    endtask

    logic [31:0] addrs [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic        exp_g [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    logic        exp_v [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    logic [31:0] exp_d [10] = '{32'h0, 32'h0, 32'h0, 32'h11, 32'hAA, 32'hAA, 32'hAA,
                                32'h33, 32'h44, 32'h44};

    initial begin
        int k;
        rst = 1'b1; ld = 1'b0; la = '0; ldd = '0;
        req1 = 1'b0; addr1 = '0; req3 = 1'b0; addr3 = '0;
        repeat (2) @(posedge clk);

        //   rst req addr        ld la          ldd        gnt rv rd         err
        add(1, 1, 32'h100, 0, 32'h0,   32'h0,  0, 0, 32'h0,  0);
        add(0, 0, 32'h0,   1, 32'h100, 32'h11, 0, 0, 32'h0,  0);
        add(0, 0, 32'h0,   1, 32'h104, 32'h22, 0, 0, 32'h0,  0);
        add(0, 0, 32'h0,   1, 32'h108, 32'h33, 0, 0, 32'h0,  0);
        add(0, 0, 32'h0,   1, 32'h10C, 32'h44, 0, 0, 32'h0,  0);
        add(0, 1, 32'h100, 0, 32'h0,   32'h0,  1, 0, 32'h0,  0);
        add(0, 1, 32'h104, 0, 32'h0,   32'h0,  1, 1, 32'h11, 0);
        add(0, 1, 32'h108, 0, 32'h0,   32'h0,  1, 1, 32'h22, 0);
        add(0, 1, 32'h10C, 0, 32'h0,   32'h0,  1, 1, 32'h33, 0);
        add(0, 0, 32'h0,   0, 32'h0,   32'h0,  0, 1, 32'h44, 0);
        add(0, 0, 32'h0,   0, 32'h0,   32'h0,  0, 0, 32'h44, 0);
        add(0, 1, 32'h102, 0, 32'h0,   32'h0,  1, 0, 32'h44, 0);
        add(0, 1, 32'h140, 0, 32'h0,   32'h0,  1, 1, 32'h13, 1);
        add(0, 1, 32'h2,   0, 32'h0,   32'h0,  1, 1, 32'h13, 1);
        add(0, 0, 32'h0,   0, 32'h0,   32'h0,  0, 1, 32'h13, 1);
        add(0, 0, 32'h0,   0, 32'h0,   32'h0,  0, 0, 32'h13, 0);
        add(0, 1, 32'h104, 1, 32'h104, 32'hAA, 0, 0, 32'h13, 0);
        add(0, 1, 32'h104, 0, 32'h0,   32'h0,  1, 0, 32'h13, 0);
        add(0, 0, 32'h0,   0, 32'h0,   32'h0,  0, 1, 32'hAA, 0);
        add(0, 0, 32'h0,   1, 32'h10D, 32'hEE, 0, 0, 32'hAA, 0);
        add(0, 0, 32'h0,   1, 32'h140, 32'hEE, 0, 0, 32'hAA, 0);
        add(0, 1, 32'h10C, 0, 32'h0,   32'h0,  1, 0, 32'hAA, 0);
        add(0, 1, 32'h100, 0, 32'h0,   32'h0,  1, 1, 32'h44, 0);
        add(0, 0, 32'h0,   0, 32'h0,   32'h0,  0, 1, 32'h11, 0);
        add(0, 1, 32'h108, 1, 32'h100, 32'h11, 0, 0, 32'h11, 0);
        add(0, 0, 32'h10C, 0, 32'h0,   32'h0,  0, 0, 32'h11, 0);
        add(0, 0, 32'h0,   0, 32'h0,   32'h0,  0, 0, 32'h11, 0);
        add(0, 1, 32'h100, 0, 32'h0,   32'h0,  1, 0, 32'h11, 0);
        add(0, 1, 32'h104, 0, 32'h0,   32'h0,  1, 1, 32'h11, 0);
        add(1, 1, 32'h108, 0, 32'h0,   32'h0,  0, 1, 32'hAA, 0);
        add(0, 0, 32'h0,   0, 32'h0,   32'h0,  0, 0, 32'h0,  0);
        add(0, 1, 32'h108, 0, 32'h0,   32'h0,  1, 0, 32'h0,  0);
        add(0, 0, 32'h0,   0, 32'h0,   32'h0,  0, 1, 32'h33, 0);

        foreach (vt[i]) begin
            @(negedge clk);
            rst = vt[i].rst; req1 = vt[i].req; addr1 = vt[i].addr;
            ld = vt[i].ld; la = vt[i].la; ldd = vt[i].ldd;
            #1;
            chk($sformatf("v%0d gnt", i), {31'b0, gnt1}, {31'b0, vt[i].gnt});
            chk($sformatf("v%0d rvalid", i), {31'b0, rv1}, {31'b0, vt[i].rv});
            chk($sformatf("v%0d rdata", i), rd1, vt[i].rd);
            chk($sformatf("v%0d err", i), {31'b0, err1}, {31'b0, vt[i].err});
        end
        rst = 1'b0; req1 = 1'b0; ld = 1'b0;

        // Latency 3 with two slots: full request pressure, grants throttle, order kept.
        k = 0;
        for (int c = 0; c < 10; c++) begin
            cyc3(0, k < 4, addrs[(k < 4) ? k : 3], 0, 32'h0, 32'h0);
            chk($sformatf("l3 c%0d gnt", c), {31'b0, gnt3}, {31'b0, exp_g[c]});
            chk($sformatf("l3 c%0d rvalid", c), {31'b0, rv3}, {31'b0, exp_v[c]});
            chk($sformatf("l3 c%0d rdata", c), rd3, exp_d[c]);
            if (gnt3 && k < 4) k++;
        end

        // Load on the read edge returns old data; a load one edge earlier is visible.
        cyc3(0, 1, 32'h104, 0, 32'h0, 32'h0);
        chk("wr_edge gnt", {31'b0, gnt3}, 32'h1);
        cyc3(0, 0, 32'h0, 0, 32'h0, 32'h0);
        cyc3(0, 0, 32'h0, 1, 32'h104, 32'hCC);
        cyc3(0, 0, 32'h0, 0, 32'h0, 32'h0);
        chk("wr_edge rvalid", {31'b0, rv3}, 32'h1);
        chk("wr_edge old data", rd3, 32'hAA);
        cyc3(0, 1, 32'h108, 0, 32'h0, 32'h0);
        chk("wr_early gnt", {31'b0, gnt3}, 32'h1);
        cyc3(0, 0, 32'h0, 1, 32'h108, 32'hDD);
        cyc3(0, 0, 32'h0, 0, 32'h0, 32'h0);
        cyc3(0, 0, 32'h0, 0, 32'h0, 32'h0);
        chk("wr_early rvalid", {31'b0, rv3}, 32'h1);
        chk("wr_early new data", rd3, 32'hDD);
        cyc3(0, 1, 32'h104, 0, 32'h0, 32'h0);
        cyc3(0, 0, 32'h0, 0, 32'h0, 32'h0);
        cyc3(0, 0, 32'h0, 0, 32'h0, 32'h0);
        cyc3(0, 0, 32'h0, 0, 32'h0, 32'h0);
        chk("reread new data", rd3, 32'hCC);

        // Reset with two requests in flight drops them and frees both slots.
        cyc3(0, 1, 32'h100, 0, 32'h0, 32'h0);
        chk("rst_fl gnt0", {31'b0, gnt3}, 32'h1);
        cyc3(0, 1, 32'h10C, 0, 32'h0, 32'h0);
        chk("rst_fl gnt1", {31'b0, gnt3}, 32'h1);
        cyc3(1, 1, 32'h108, 0, 32'h0, 32'h0);
        chk("rst_fl gnt in rst", {31'b0, gnt3}, 32'h0);
        cyc3(0, 1, 32'h100, 0, 32'h0, 32'h0);
        chk("rst_fl gnt after", {31'b0, gnt3}, 32'h1);
        chk("rst_fl rvalid r3", {31'b0, rv3}, 32'h0);
        chk("rst_fl rdata", rd3, 32'h0);
        chk("rst_fl err", {31'b0, err3}, 32'h0);
        cyc3(0, 0, 32'h0, 0, 32'h0, 32'h0);
        chk("rst_fl rvalid r4", {31'b0, rv3}, 32'h0);
        cyc3(0, 0, 32'h0, 0, 32'h0, 32'h0);
        chk("rst_fl rvalid r5", {31'b0, rv3}, 32'h0);
        cyc3(0, 0, 32'h0, 0, 32'h0, 32'h0);
        chk("rst_fl rvalid r6", {31'b0, rv3}, 32'h1);
        chk("rst_fl kept data", rd3, 32'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
